rom_burst_reader: RTL and testbench

Burst read sequencer that sits directly upstream of the synchronous 16x8 single-port ROM. On a start command it issues a programmable run of consecutive ROM reads, absorbs the ROM's one-cycle read latency, and presents the returned bytes as a valid/ready byte stream with a last marker. Downstream consumers (UART/display/test stages) get back-pressured streaming without needing to know the ROM timing.

---
 rtl/rom_burst_pkg.sv | 16 +
 rtl/rom_burst_reader_if.sv | 29 ++
 rtl/rom_out_fifo.sv | 51 +++++
 rtl/rom_burst_reader.sv | 157 +++++++++++++++
 tb/tb_rom_burst_reader.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_burst_pkg.sv
// rom_burst_pkg: shared widths, ROM depth and FSM state encoding for the
// ROM burst reader and its output FIFO.
package rom_burst_pkg;

  localparam int ROM_ADDR_W  = 4;
  localparam int ROM_DATA_W  = 8;
  localparam int BURST_LEN_W = 5;
  localparam int ROM_DEPTH   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rom_burst_reader_if.sv
// rom_burst_reader_if: valid/ready byte stream leaving the ROM burst reader.
//   m_valid  byte available (driven by master)
//   m_ready  consumer accepts byte on m_valid && m_ready (driven by slave)
//   m_data   stream byte (driven by master)
//   m_last   final byte of the burst (driven by master)
interface rom_burst_reader_if #(
  parameter int DATA_W = rom_burst_pkg::ROM_DATA_W
);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/rom_out_fifo.sv
// rom_out_fifo: 2-entry synchronous FIFO of {last, data}.
//   clk, rst              clock, synchronous active-high reset
//   push, push_data/last  write an entry (caller guarantees not full)
//   pop                   remove head entry (caller guarantees not empty)
//   head_data/head_last   current head entry
//   count                 number of stored entries (0..2)
module rom_out_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] data_q [2];
  logic              last_q [2];
  logic              wr_q;
  logic              rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_q] <= push_data;
        last_q[wr_q] <= push_last;
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head_data = data_q[rd_q];
  assign head_last = last_q[rd_q];

endmodule

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: issues a run of consecutive reads to a synchronous
// single-port ROM (one-cycle read latency) and presents the returned bytes
// as a back-pressured valid/ready stream with a last marker.
//   clk, rst     clock, synchronous active-high reset
//   start        command strobe, accepted only when idle
//   start_addr   first ROM address of the burst
//   length       byte count, values above ROM_DEPTH clamp to ROM_DEPTH
//   busy, done   burst in progress / one-cycle completion pulse
//   rom_en/addr  ROM read strobe and address; rom_data returns next cycle
//   m            stream master (m_valid, m_ready, m_data, m_last)
//   checksum     mod-256 sum of bytes popped this burst (CHECKSUM_EN only)
// Optional feature macro: CHECKSUM_EN.
module rom_burst_reader
  import rom_burst_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W,
  parameter int LEN_W  = BURST_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  rom_burst_reader_if.master m
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(ROM_DEPTH)) begin
      return LEN_W'(ROM_DEPTH);
    end
    return len;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              done_q;
  logic              vld_p1;
  logic              last_p1;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;
  logic              pop;
  logic              issue;
  logic              drain_exit;
  logic              start_ok;
  logic [LEN_W-1:0]  len_clamped;

  assign len_clamped = clamp_len(length);
  assign start_ok    = (state_q == IDLE) && start;
  assign pop         = m.m_valid && m.m_ready;
  // Bytes already committed to the FIFO: stored plus the one in flight.
  assign occ         = 3'(fifo_count) + 3'(vld_p1);

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    drain_exit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (len_clamped != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A byte popped this cycle frees a slot for the read issued now.
        issue = (rem_q != '0) && (occ < (3'd2 + 3'(pop)));
        if (issue && (rem_q == LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_exit = !vld_p1 && (fifo_count == 2'(pop));
        if (drain_exit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: read issue
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_addr_q <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= drain_exit || (start_ok && (len_clamped == '0));
      vld_p1  <= issue;
      if (start_ok) begin
        ptr_q <= start_addr;
        rem_q <= len_clamped;
      end
      if (issue) begin
        ptr_q       <= ptr_q + ADDR_W'(1);
        last_addr_q <= ptr_q;
        rem_q       <= rem_q - LEN_W'(1);
        last_p1     <= (rem_q == LEN_W'(1));
      end
    end
  end

  // Stage p1: ROM data returns and is captured into the output FIFO
  rom_out_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data (rom_data),
    .push_last (last_p1),
    .pop       (pop),
    .head_data (m.m_data),
    .head_last (m.m_last),
    .count     (fifo_count)
  );

  assign m.m_valid = (fifo_count != 2'd0);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rom_en    = issue;
  // Address is only meaningful with rom_en; otherwise show the last one issued.
  assign rom_addr  = issue ? ptr_q : last_addr_q;

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + m.m_data;
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: directed bench for rom_burst_reader. A ROM model
// returns {addr, addr} one cycle after rom_en, so address a reads 8'h11*a.
// Checksum checks are compiled when CHECKSUM_EN is defined.
module tb_rom_burst_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] length;
  logic       busy;
  logic       done;
  logic       rom_en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
`ifdef CHECKSUM_EN
  logic [7:0] checksum;
`endif

  rom_burst_reader_if bus ();

  rom_burst_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .m          (bus)
`ifdef CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rom_en) rom_data <= {rom_addr, rom_addr};
  end

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_done = 0;
  int         n_issue = 0;
  logic [7:0] got_d[$];
  logic       got_l[$];

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      got_d.push_back(bus.m_data);
      got_l.push_back(bus.m_last);
    end
    if (done) n_done++;
    if (rom_en) n_issue++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare bytes popped since index base against ROM contents addr, addr+1, ...
  task automatic chk_stream(input string tag, input int base, input logic [3:0] addr, input int n);
    logic [3:0] a;
    chk({tag, "_count"}, 32'(got_d.size() - base), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (base + k < got_d.size()) begin
        a = addr + 4'(k);
        chk($sformatf("%s_d%0d", tag, k), 32'(got_d[base + k]), 32'({a, a}));
        chk($sformatf("%s_l%0d", tag, k), 32'(got_l[base + k]), 32'(k == n - 1));
      end
    end
  endtask

  task automatic run_burst(input string tag, input logic [3:0] addr, input logic [4:0] len,
                           input logic [15:0] pat, input int n_exp);
    int base;
    int d0;
    int i0;
    int cyc;
    base = got_d.size();
    d0   = n_done;
    i0   = n_issue;
    start = 1'b1; start_addr = addr; length = len; bus.m_ready = pat[0];
    tick();
    start = 1'b0;
    cyc = 0;
    while (n_done == d0 && cyc < 200) begin
      bus.m_ready = pat[(cyc + 1) % 16];
      tick();
      cyc++;
    end
    chk({tag, "_timeout"}, 32'(cyc < 200), 32'd1);
    bus.m_ready = 1'b1;
    chk_stream(tag, base, addr, n_exp);
    chk({tag, "_issues"}, 32'(n_issue - i0), 32'(n_exp));
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int base;
    int d0;
    int i0;

    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; bus.m_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_data", 32'(bus.m_data), 0);
    chk("rst_m_last", 32'(bus.m_last), 0);
`ifdef CHECKSUM_EN
    chk("rst_checksum", 32'(checksum), 0);
`endif
    rst = 1'b0;
    i0 = n_issue;
    for (int k = 0; k < 5; k++) tick();
    chk("idle_no_rom_en", 32'(n_issue - i0), 0);
    chk("idle_busy", 32'(busy), 0);

    // Cycle-exact burst: addr 2, length 4, consumer always ready.
    base = got_d.size(); d0 = n_done; i0 = n_issue;
    start = 1'b1; start_addr = 4'd2; length = 5'd4; bus.m_ready = 1'b1;
    #1 chk("t1_busy_T0", 32'(busy), 0);
    tick(); start = 1'b0; #1;
    chk("t1_busy_T1", 32'(busy), 1);
    chk("t1_rom_en_T1", 32'(rom_en), 1);
    chk("t1_rom_addr_T1", 32'(rom_addr), 2);
    tick(); #1;
    chk("t1_rom_addr_T2", 32'(rom_addr), 3);
    chk("t1_valid_T2", 32'(bus.m_valid), 0);
    tick(); #1;
    chk("t1_valid_T3", 32'(bus.m_valid), 1);
    chk("t1_data_T3", 32'(bus.m_data), 32'h22);
    chk("t1_last_T3", 32'(bus.m_last), 0);
    tick(); #1;
    chk("t1_data_T4", 32'(bus.m_data), 32'h33);
    tick(); #1;
    chk("t1_data_T5", 32'(bus.m_data), 32'h44);
    tick(); #1;
    chk("t1_data_T6", 32'(bus.m_data), 32'h55);
    chk("t1_last_T6", 32'(bus.m_last), 1);
    chk("t1_done_T6", 32'(done), 0);
    tick(); #1;
    chk("t1_done_T7", 32'(done), 1);
    chk("t1_busy_T7", 32'(busy), 0);
    chk("t1_valid_T7", 32'(bus.m_valid), 0);
    tick(); #1;
    chk("t1_done_T8", 32'(done), 0);
    chk("t1_rom_addr_hold", 32'(rom_addr), 5);
    chk("t1_issues", 32'(n_issue - i0), 4);
    chk("t1_dones", 32'(n_done - d0), 1);
    chk_stream("t1", base, 4'd2, 4);

    // Address wrap: EE, FF, 00.
    tick();
    run_burst("wrap", 4'd14, 5'd3, 16'hFFFF, 3);

    // Back-pressure: first byte popped, then m_ready low for 5 cycles.
    tick();
    base = got_d.size(); d0 = n_done; i0 = n_issue;
    start = 1'b1; start_addr = 4'd5; length = 5'd6; bus.m_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    #1 chk("st_first", 32'(bus.m_data), 32'h55);
    tick(); bus.m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k > 0) begin
        chk($sformatf("st_rom_en_%0d", k), 32'(rom_en), 0);
      end
      chk($sformatf("st_valid_%0d", k), 32'(bus.m_valid), 1);
      chk($sformatf("st_data_%0d", k), 32'(bus.m_data), 32'h66);
      chk($sformatf("st_last_%0d", k), 32'(bus.m_last), 0);
      if (k == 2) chk("st_rom_addr_hold", 32'(rom_addr), 7);
      tick();
    end
    bus.m_ready = 1'b1;
    for (int k = 0; k < 40 && n_done == d0; k++) tick();
    chk("st_done", 32'(n_done - d0), 1);
    chk("st_issues", 32'(n_issue - i0), 6);
    chk_stream("st", base, 4'd5, 6);

    // Irregular consumer pattern and length clamp (20 -> 16, wraps from 8).
    tick();
    run_burst("clamp", 4'd8, 5'd20, 16'hA5C3, 16);
    tick();
    run_burst("toggle", 4'd11, 5'd7, 16'h5555, 7);

    // Zero length: done next cycle, no reads, no stream.
    tick();
    d0 = n_done; i0 = n_issue; base = got_d.size();
    start = 1'b1; start_addr = 4'd7; length = 5'd0;
    tick(); start = 1'b0; #1;
    chk("z_done", 32'(done), 1);
    chk("z_busy", 32'(busy), 0);
    chk("z_valid", 32'(bus.m_valid), 0);
    tick(); #1;
    chk("z_done_pulse", 32'(done), 0);
    chk("z_issues", 32'(n_issue - i0), 0);
    chk("z_bytes", 32'(got_d.size() - base), 0);

    // Start while busy is ignored.
    tick();
    base = got_d.size(); d0 = n_done; i0 = n_issue;
    start = 1'b1; start_addr = 4'd1; length = 5'd3;
    tick(); start = 1'b0;
    tick();
    start = 1'b1; start_addr = 4'd9; length = 5'd5;
    tick(); start = 1'b0;
    for (int k = 0; k < 40 && n_done == d0; k++) tick();
    for (int k = 0; k < 4; k++) tick();
    chk("ign_dones", 32'(n_done - d0), 1);
    chk("ign_issues", 32'(n_issue - i0), 3);
    chk("ign_busy", 32'(busy), 0);
    chk_stream("ign", base, 4'd1, 3);

    // Reset mid-burst.
    tick();
    d0 = n_done;
    start = 1'b1; start_addr = 4'd3; length = 5'd8;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); #1;
    chk("mr_valid", 32'(bus.m_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_rom_en", 32'(rom_en), 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("mr_no_done", 32'(n_done - d0), 0);
    chk("mr_idle_valid", 32'(bus.m_valid), 0);
    run_burst("post_rst", 4'd2, 5'd4, 16'hFFFF, 4);

    // Full ROM sweep 00..FF; checksum 0x11*120 mod 256 = F8.
    tick();
    run_burst("full", 4'd0, 5'd16, 16'hFFFF, 16);
`ifdef CHECKSUM_EN
    chk("cks_full", 32'(checksum), 32'hF8);
    tick(); tick();
    chk("cks_hold", 32'(checksum), 32'hF8);
    run_burst("cks_wrap", 4'd14, 5'd3, 16'hFFFF, 3);
    chk("cks_wrap_sum", 32'(checksum), 32'hED);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
